// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH cycles per result.
// diff/borr are updated only when the last bit is processed and hold until the next accepted start.
//
// state | meaning
// IDLE  | waiting for start; the last result is held on diff/borr
// SHIFT | one bit per edge; busy=1
// DONE  | result valid; done=1 for one cycle, then back to IDLE
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bin;
  logic [CW-1:0]    cnt;

  logic             hs1_d;
  logic             hs1_b;
  logic             d;
  logic             bout;
  logic [WIDTH-1:0] res_nxt;

  // Full subtractor from two half subtractors: (x - y), then (that - bin).
  always_comb begin
    hs1_d   = a_sr[0] ^ b_sr[0];
    hs1_b   = ~a_sr[0] & b_sr[0];
    d       = hs1_d ^ bin;
    bout    = hs1_b | (~hs1_d & bin);
    res_nxt = {d, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= res_nxt;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          bin    <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= res_nxt;
            borr  <= bout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
